// File: rtl/logic_module.sv
// rtl/logic_module.sv - eFPGA logic element: fracturable LUT5 / dual LUT4 plus optional flip-flop (macro LOGIC_MODULE_FF_EN)
module logic_module (
    input  logic        reg_clk,
    input  logic        reg_nres,
    input  logic [33:0] prog,
    input  logic        reg_in,
    input  logic [4:0]  data_in,
    output logic [1:0]  data_out
);

    logic [15:0] tt_a;
    logic [15:0] tt_b;
    logic        frac;
    logic        dsel;
    logic        lut_a;
    logic        lut_b;
    logic        lut5;
    logic        comb_out;
    logic        ff_lut_src;
    logic        ff_d;

    assign tt_a = prog[15:0];
    assign tt_b = prog[31:16];
    assign frac = prog[32];
    assign dsel = prog[33];

    // LUT lookup, fracture selection and register-input selection
    always_comb begin
        lut_a      = tt_a[data_in[3:0]];
        lut_b      = tt_b[data_in[3:0]];
        lut5       = data_in[4] ? lut_b : lut_a;
        comb_out   = lut5;
        ff_lut_src = lut5;
        if (frac) begin
            // data_in[4] is don't-care here: each half sees only the low four inputs
            comb_out   = lut_a;
            ff_lut_src = lut_b;
        end
        ff_d = dsel ? reg_in : ff_lut_src;
    end

`ifdef LOGIC_MODULE_FF_EN
    logic ff_q;

    // Output register with asynchronous clear
    always_ff @(posedge reg_clk or negedge reg_nres) begin
        if (!reg_nres) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign data_out = {ff_q, comb_out};
`else
    // Combinational-only tile: clock and reset pins remain for a uniform tile interface
    logic unused_clk_rst;
    assign unused_clk_rst = reg_clk ^ reg_nres;

    assign data_out = {ff_d, comb_out};
`endif

endmodule

// File: tb/tb_logic_module.sv
// tb/tb_logic_module.sv - scoreboard bench for logic_module (both LOGIC_MODULE_FF_EN builds)
module tb_logic_module;

    logic        reg_clk  = 1'b0;
    logic        reg_nres = 1'b1;
    logic [33:0] prog     = '0;
    logic        reg_in   = 1'b0;
    logic [4:0]  data_in  = '0;
    logic [1:0]  data_out;

    logic        mq = 1'b0;
    int          n_pass  = 0;
    int          n_total = 0;

    typedef struct {
        string tag;
        int    idx;
        logic  val;
    } exp_t;

    exp_t sb[$];

    logic_module dut (
        .reg_clk  (reg_clk),
        .reg_nres (reg_nres),
        .prog     (prog),
        .reg_in   (reg_in),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 reg_clk = ~reg_clk;

    function automatic logic m_comb(input logic [33:0] p, input logic [4:0] d);
        logic [33:0] s;
        if (p[32]) s = p >> {1'b0, d[3:0]};
        else       s = p >> d;
        return s[0];
    endfunction

    function automatic logic m_ffd(input logic [33:0] p, input logic [4:0] d, input logic r);
        logic [33:0] s;
        if (p[33]) return r;
        if (p[32]) s = p >> (5'd16 + {1'b0, d[3:0]});
        else       s = p >> d;
        return s[0];
    endfunction

    // Reference register tracking the inputs seen at each edge
    always @(posedge reg_clk or negedge reg_nres) begin
        if (!reg_nres) mq <= 1'b0;
        else           mq <= m_ffd(prog, data_in, reg_in);
    end

    function automatic logic exp1();
`ifdef LOGIC_MODULE_FF_EN
        return mq;
`else
        return m_ffd(prog, data_in, reg_in);
`endif
    endfunction

    task automatic push(input string tag, input int idx, input logic v);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            assert (data_out[e.idx] === e.val) n_pass++;
            else $error("FAIL %s: data_out[%0d]=%b expected %b", e.tag, e.idx, data_out[e.idx], e.val);
        end
    endtask

    task automatic edge_check(input string tag);
        @(posedge reg_clk);
        #1;
        push(tag, 1, exp1());
        drain();
    endtask

    initial begin
        logic [31:0] pat;
        pat = 32'h3ACA3ACA;

        // reset state
        prog    = 34'h23ACA3ACA;
        reg_in  = 1'b0;
        data_in = 5'h00;
        #1 reg_nres = 1'b0;
        #1;
        push("reset_out0", 0, 1'b0);
        push("reset_out1", 1, 1'b0);
        drain();

        @(negedge reg_clk);
        reg_nres = 1'b1;

        // LUT5 sweep, register bypass holding reg_in=0
        for (int i = 0; i < 32; i++) begin
            @(negedge reg_clk);
            data_in = 5'(i);
            #1;
            push("sweep_out0", 0, pat[i]);
            push("sweep_out1", 1, 1'b0);
            drain();
        end

        // bypass capture, then asynchronous clear between edges
        @(negedge reg_clk);
        reg_in = 1'b1;
        #1;
        push("bypass_pre_edge", 1, exp1());
        drain();
        edge_check("bypass_edge");
        push("bypass_after_edge", 1, 1'b1);
        drain();
        #2 reg_nres = 1'b0;
        #1;
`ifdef LOGIC_MODULE_FF_EN
        push("async_clear", 1, 1'b0);
`else
        push("async_clear", 1, 1'b1);
`endif
        drain();

        // reset held across edges with ff_d=1; LUT output keeps tracking
        for (int i = 0; i < 4; i++) begin
            @(negedge reg_clk);
            data_in = 5'(i);
            #1;
            push("rst_hold_out0", 0, pat[i]);
            drain();
            edge_check("rst_hold_out1");
        end
        @(negedge reg_clk);
        reg_nres = 1'b1;

        // LUT5 mode, register fed from LUT
        prog    = 34'h0FFFF0000;
        data_in = 5'h0F;
        #1;
        push("lut5_0F_out0", 0, 1'b0);
        drain();
        edge_check("lut5_0F_out1");
        push("lut5_0F_q", 1, 1'b0);
        drain();
        @(negedge reg_clk);
        data_in = 5'h10;
        #1;
        push("lut5_10_out0", 0, 1'b1);
        drain();
        edge_check("lut5_10_out1");
        push("lut5_10_q", 1, 1'b1);
        drain();

        // fractured mode: LUT_A all zero, LUT_B all one
        @(negedge reg_clk);
        prog    = 34'h1FFFF0000;
        data_in = 5'h00;
        edge_check("frac_clear");
        @(negedge reg_clk);
        data_in = 5'h05;
        #1;
        push("frac_05_out0", 0, 1'b0);
        drain();
        edge_check("frac_05_out1");
        push("frac_05_q", 1, 1'b1);
        drain();
        @(negedge reg_clk);
        data_in = 5'h15;
        #1;
        push("frac_15_out0", 0, 1'b0);
        drain();
        edge_check("frac_15_out1");
        push("frac_15_q", 1, 1'b1);
        drain();

        // toggle reg_in between edges with DSEL=1
        @(negedge reg_clk);
        prog = 34'h23ACA3ACA;
        for (int i = 0; i < 4; i++) begin
            #1 reg_in = ~reg_in;
            #1;
            push("reg_in_toggle", 1, exp1());
            drain();
        end

        // randomised configurations and inputs
        for (int i = 0; i < 40; i++) begin
            @(negedge reg_clk);
            prog    = {2'($urandom_range(0, 3)), $urandom()};
            data_in = 5'($urandom_range(0, 31));
            reg_in  = 1'($urandom_range(0, 1));
            #1;
            push("rand_out0", 0, m_comb(prog, data_in));
            push("rand_out1_pre", 1, exp1());
            drain();
            edge_check("rand_out1_edge");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
